// File: rtl/aes_req_arbiter.sv
// Round-robin front end that shares one AES core between two requesters.
// It launches one job at a time, applies a watchdog timeout and returns the result on a valid/ready channel.
module aes_req_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid0,
    input  logic         req_valid1,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_key1,
    output logic         req_ready0,
    output logic         req_ready1,
    output logic         resp_valid0,
    output logic         resp_valid1,
    input  logic         resp_ready0,
    input  logic         resp_ready1,
    output logic [127:0] resp_data,
    output logic         resp_err,
    output logic         aes_valid,
    output logic [127:0] aes_datain,
    output logic [127:0] aes_key,
    input  logic         aes_done,
    input  logic [127:0] aes_dataout,
    output logic         busy,
    output logic         grant_id
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] count;
    logic [127:0]  op_data;
    logic [127:0]  op_key;
    logic          any_req;
    logic          pick1;
    logic          resp_ack;

    // On contention the requester that did not win last time is chosen.
    assign any_req    = req_valid0 | req_valid1;
    assign pick1      = req_valid1 & (~req_valid0 | ~last_grant);
    assign req_ready0 = (state == IDLE) & req_valid0 & ~pick1;
    assign req_ready1 = (state == IDLE) & pick1;
    assign resp_ack   = grant_id ? resp_ready1 : resp_ready0;

    assign aes_datain = op_data;
    assign aes_key    = op_key;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            count       <= '0;
            op_data     <= '0;
            op_key      <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            resp_valid0 <= 1'b0;
            resp_valid1 <= 1'b0;
            aes_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick1;
                        op_data   <= pick1 ? req_data1 : req_data0;
                        op_key    <= pick1 ? req_key1 : req_key0;
                        aes_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    aes_valid <= 1'b0;
                    count     <= '0;
                    state     <= BUSY;
                end
                BUSY: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (aes_done) begin
                        resp_data   <= aes_dataout;
                        resp_err    <= 1'b0;
                        resp_valid0 <= ~grant_id;
                        resp_valid1 <= grant_id;
                        state       <= RESP;
                    end else if (count == LAST) begin
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        resp_valid0 <= ~grant_id;
                        resp_valid1 <= grant_id;
                        state       <= RESP;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ack) begin
                        resp_valid0 <= 1'b0;
                        resp_valid1 <= 1'b0;
                        busy        <= 1'b0;
                        last_grant  <= grant_id;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
